multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
Multi-cycle main control FSM for the RV datapath. It drives the ALUOp[1:0] and Func[3:0] inputs that the ALU control unit decodes. It sequences fetch, decode, execute, memory and writeback for ld, sd, R-type and beq, with a ready handshake to the shared instruction/data memory. Illegal opcodes trap, and retired instructions are counted.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12] from IR
funct7b5  in  1  instr[30] from IR
mem_ready  in  1  memory completes current read/write this cycle
ALUOp  out  2  to ALU control: 00 add, 01 sub (branch), 10 use Func
Func  out  4  registered {funct7b5, funct3} to ALU control
ALUSrcA  out  1  0 = PC, 1 = rs1 register A
ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = immediate
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  PC write if ALU zero
PCSource  out  1  0 = ALU result, 1 = ALUOut
RegWrite  out  1  register file write
MemtoReg  out  1  writeback: 0 = ALUOut, 1 = MDR
illegal  out  1  sticky trap flag
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, Func = 0, illegal = 0, retired = 0.
- In IDLE and TRAP, every control output is 0.
- Outputs are Moore decodes of state, except IRWrite/PCWrite in FETCH, which are gated by mem_ready.
- Unlisted outputs are 0 in every state.
- Opcode constants: LD = 0000011, SD = 0100011, RTYPE = 0110011, BEQ = 1100011.
- IDLE: unconditionally -> FETCH next cycle.
- FETCH:
  - Drives MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00.
  - Holds while mem_ready = 0.
  - On mem_ready = 1: IRWrite = 1, PCWrite = 1, PCSource = 0, then -> DECODE.
- DECODE:
  - Drives ALUSrcA = 0, ALUSrcB = 10, ALUOp = 00 (branch target into ALUOut).
  - Func <= {funct7b5, funct3}; Func is updated only in this state.
  - Next: LD/SD -> MEM_ADDR; RTYPE -> EXEC_R; BEQ -> BRANCH; any other opcode -> TRAP.
  - Records ld/sd class in an internal bit used by MEM_ADDR.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00; -> MEM_RD (ld) or MEM_WR (sd).
- MEM_RD: MemRead = 1, IorD = 1; hold until mem_ready, then -> LOAD_WB.
- LOAD_WB: RegWrite = 1, MemtoReg = 1; retire; -> FETCH.
- MEM_WR: MemWrite = 1, IorD = 1; hold until mem_ready, then retire and -> FETCH.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; -> ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 0; retire; -> FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 1; retire; -> FETCH.
- TRAP: illegal = 1, sticky. Stays in TRAP until rst_n is low; no memory or register writes occur.
- Latency in cycles, excluding memory wait cycles: ld 5, sd 4, R-type 4, beq 3.
- Retirement: retired increments by 1 on the retire cycle and wraps modulo 2^CNT_W.
- mem_ready is ignored in states without a memory request.
- MemRead and MemWrite are never asserted together.
- Reset asserted mid-instruction returns to IDLE immediately with no further writes.

Decomposition:
- Shared package holds:
  - state enum: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, LOAD_WB, MEM_WR, EXEC_R, ALU_WB, BRANCH, TRAP; 4-bit encoding
  - opcode constants
  - ALUOp codes: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC
  - ALUSrcB codes: SRCB_REG, SRCB_FOUR, SRCB_IMM
- Single module. State register, Func register and counter are small; output decode is one case statement. No sub-module.

Test Plan:
- Reset then mem_ready = 1 constantly, opcode 0110011, funct7b5 = 1, funct3 = 000 -> states IDLE, FETCH, DECODE, EXEC_R, ALU_WB; Func = 4'b1000 with ALUOp = 10 in EXEC_R; RegWrite = 1 in ALU_WB; retired = 1.
- ld with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM_RD -> IRWrite/PCWrite pulse exactly once; MemRead held throughout the waits; LOAD_WB has MemtoReg = 1; total 10 cycles from FETCH entry.
- sd -> MEM_WR has MemWrite = 1, IorD = 1; RegWrite never asserted; retired increments at mem_ready.
- beq -> BRANCH has ALUOp = 01, PCWriteCond = 1, PCSource = 1; returns to FETCH; 3-cycle instruction.
- opcode 1111111 -> TRAP; illegal = 1 and all controls 0 for 20 cycles; only rst_n low clears it.
- rst_n dropped mid MEM_WR and CNT_W = 4 wrap test (16 R-types) -> MemWrite falls asynchronously, state IDLE; after the 16 R-types, retired = 0.

Source files
------------

// File: rtl/multicycle_main_control_pkg.sv
// Shared types and constants for the multi-cycle main control FSM.
// Holds the state enum, opcode constants and ALUOp/ALUSrcB codes.
package multicycle_main_control_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    LOAD_WB  = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM: fetch/decode/execute/mem/writeback
// for ld, sd, R-type, beq. Inputs: clk, rst_n, opcode, funct3,
// funct7b5, mem_ready. Outputs: datapath controls, Func, illegal
// trap flag and retired-instruction counter.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic [3:0]       Func,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCSource,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t state, state_nxt;
  logic   is_ld;
  logic   retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      Func    <= '0;
      is_ld   <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) begin
        Func  <= {funct7b5, funct3};
        is_ld <= (opcode == OP_LD);
      end
      // TRAP is absorbing, so setting on entry keeps the flag sticky.
      if (state_nxt == TRAP)
        illegal <= 1'b1;
      if (retire)
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    unique case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM;
        unique case (1'b1)
          (opcode == OP_LD),
          (opcode == OP_SD):    state_nxt = MEM_ADDR;
          (opcode == OP_RTYPE): state_nxt = EXEC_R;
          (opcode == OP_BEQ):   state_nxt = BRANCH;
          default:              state_nxt = TRAP;
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = is_ld ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)
          state_nxt = LOAD_WB;
      end
      LOAD_WB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      EXEC_R: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALUOP_FUNC;
        state_nxt = ALU_WB;
      end
      ALU_WB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        retire      = 1'b1;
        state_nxt   = FETCH;
      end
      TRAP: state_nxt = TRAP;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized bench for multicycle_main_control with a step-table
// reference model built per instruction class.
module tb_multicycle_main_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic          funct7b5 = 1'b0;
  logic          mem_ready = 1'b0;
  logic [1:0]    ALUOp;
  logic [3:0]    Func;
  logic          ALUSrcA;
  logic [1:0]    ALUSrcB;
  logic          IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic          PCWriteCond, PCSource, RegWrite, MemtoReg;
  logic          illegal;
  logic [CW-1:0] retired;

  multicycle_main_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .mem_ready(mem_ready), .ALUOp(ALUOp),
    .Func(Func), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0]    m_func;
  logic [CW-1:0] m_ret;
  logic          m_ill;

  wire [14:0] obs = {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead,
                     MemWrite, IRWrite, PCWrite, PCWriteCond,
                     PCSource, RegWrite, MemtoReg};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ctl(
    input logic [1:0] aop, input logic sa, input logic [1:0] sb,
    input logic iord, input logic mr, input logic mw,
    input logic irw, input logic pcw, input logic pcwc,
    input logic pcs, input logic rw, input logic m2r);
    return {aop, sa, sb, iord, mr, mw, irw, pcw, pcwc, pcs, rw, m2r};
  endfunction

  // One cycle: drive mem_ready, check all outputs, advance.
  task automatic step(input string tag, input logic mr,
                      input logic [14:0] exp, input logic ret);
    mem_ready = mr;
    #1;
    chk({tag, ".ctl"}, 32'(obs), 32'(exp));
    chk({tag, ".func"}, 32'(Func), 32'(m_func));
    chk({tag, ".ill"}, 32'(illegal), 32'(m_ill));
    chk({tag, ".ret"}, 32'(retired), 32'(m_ret));
    @(negedge clk);
    if (ret) m_ret = m_ret + 1'b1;
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    m_func = '0;
    m_ret = '0;
    m_ill = 1'b0;
    #1;
    chk("rst.ctl", 32'(obs), 0);
    chk("rst.func", 32'(Func), 0);
    chk("rst.ill", 32'(illegal), 0);
    chk("rst.ret", 32'(retired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", rnd(), '0, 1'b0);
  endtask

  task automatic fetch_dec(input logic [6:0] op, input logic f7,
                           input logic [2:0] f3, input int wf);
    opcode = op;
    funct7b5 = f7;
    funct3 = f3;
    for (int i = 0; i < wf; i++)
      step("fetchw", 1'b0, ctl(0,0,1,0,1,0,0,0,0,0,0,0), 1'b0);
    step("fetch", 1'b1, ctl(0,0,1,0,1,0,1,1,0,0,0,0), 1'b0);
    step("decode", rnd(), ctl(0,0,2,0,0,0,0,0,0,0,0,0), 1'b0);
    m_func = {f7, f3};
  endtask

  // kind: 0 ld, 1 sd, 2 R-type, 3 beq
  task automatic run_instr(input int kind, input logic f7,
                           input logic [2:0] f3, input int wf,
                           input int wm);
    logic [6:0] op;
    case (kind)
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      default: op = 7'b1100011;
    endcase
    fetch_dec(op, f7, f3, wf);
    case (kind)
      0: begin
        step("maddr", rnd(), ctl(0,1,2,0,0,0,0,0,0,0,0,0), 1'b0);
        for (int i = 0; i < wm; i++)
          step("memrdw", 1'b0, ctl(0,0,0,1,1,0,0,0,0,0,0,0), 1'b0);
        step("memrd", 1'b1, ctl(0,0,0,1,1,0,0,0,0,0,0,0), 1'b0);
        step("loadwb", rnd(), ctl(0,0,0,0,0,0,0,0,0,0,1,1), 1'b1);
      end
      1: begin
        step("maddr", rnd(), ctl(0,1,2,0,0,0,0,0,0,0,0,0), 1'b0);
        for (int i = 0; i < wm; i++)
          step("memwrw", 1'b0, ctl(0,0,0,1,0,1,0,0,0,0,0,0), 1'b0);
        step("memwr", 1'b1, ctl(0,0,0,1,0,1,0,0,0,0,0,0), 1'b1);
      end
      2: begin
        step("execr", rnd(), ctl(2,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
        step("aluwb", rnd(), ctl(0,0,0,0,0,0,0,0,0,0,1,0), 1'b1);
      end
      default:
        step("branch", rnd(), ctl(1,1,0,0,0,0,0,0,1,1,0,0), 1'b1);
    endcase
  endtask

  initial begin
    #2;
    do_reset();

    run_instr(2, 1'b1, 3'b000, 0, 0);
    chk("rtype.retired", 32'(retired), 1);
    run_instr(0, 1'b0, 3'b011, 3, 2);
    run_instr(1, 1'b0, 3'b011, 1, 2);
    run_instr(3, 1'b0, 3'b000, 0, 0);
    run_instr(1, 1'b1, 3'b111, 0, 0);

    for (int n = 0; n < 40; n++)
      run_instr(int'($urandom_range(0, 3)), rnd(),
                3'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));

    fetch_dec(7'b1111111, rnd(), 3'($urandom), 1);
    m_ill = 1'b1;
    for (int i = 0; i < 20; i++)
      step("trap", rnd(), '0, 1'b0);
    do_reset();

    fetch_dec(7'b0100011, 1'b0, 3'b011, 0);
    step("maddr", rnd(), ctl(0,1,2,0,0,0,0,0,0,0,0,0), 1'b0);
    step("memwrw", 1'b0, ctl(0,0,0,1,0,1,0,0,0,0,0,0), 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("midwr.memwrite", 32'(MemWrite), 1);
    rst_n = 1'b0;
    m_func = '0;
    m_ret = '0;
    m_ill = 1'b0;
    #1;
    chk("midwr.rst.ctl", 32'(obs), 0);
    chk("midwr.rst.func", 32'(Func), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", rnd(), '0, 1'b0);

    for (int i = 0; i < 16; i++)
      run_instr(2, rnd(), 3'($urandom), 0, 0);
    chk("wrap.retired", 32'(retired), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
